// File: rtl/ram_tgm_pkg.sv
// Shared types and constants for the TGM output-RAM reader: state encoding,
// bus widths and the payload-truncation helper.
package ram_tgm_pkg;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 32;
  localparam int PAYLOAD_W  = 8;
  localparam int MAX_LEN    = 256;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // A RAM word carries only an 8-bit payload; any set bit above it is lost.
  function automatic logic has_trunc(input logic [DATA_W-1:0] word);
    return |word[DATA_W-1:PAYLOAD_W];
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with combinational head; a push and a pop in the
// same cycle are accepted even when the FIFO is full.
module byte_fifo
  import ram_tgm_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             din_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & ((count_q != CNT_W'(DEPTH)) | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ram_to_tgm_reader.sv
// Reads a block of words from the TGM output RAM and streams their low bytes
// over valid/ready, issuing reads only when the output FIFO has room for them.
module ram_to_tgm_reader #(
  parameter int ADDR_W     = ram_tgm_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [ADDR_W-1:0]                  base_addr,
  input  logic [ADDR_W:0]                    length,
  output logic                               ram_rd,
  output logic [ADDR_W-1:0]                  ram_addr,
  input  logic [ram_tgm_pkg::DATA_W-1:0]     ram_data,
  output logic [ram_tgm_pkg::PAYLOAD_W-1:0]  out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_last,
  output logic                               busy,
  output logic                               done,
  output logic                               trunc_err
);
  import ram_tgm_pkg::*;

  localparam int LEN_W = ADDR_W + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]     rd_left_q, rd_left_d;
  logic [LEN_W-1:0]     pop_left_q, pop_left_d;
  logic                 inflight_q;
  logic                 done_q, done_d;
  logic                 trunc_q, trunc_d;

  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_empty;
  logic [PAYLOAD_W-1:0] fifo_head;
  logic                 pop;
  logic                 issue;
  logic [CNT_W:0]       occupancy;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PAYLOAD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .din_i   (ram_data[PAYLOAD_W-1:0]),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = out_valid ? fifo_head : '0;
  assign pop       = out_valid & out_ready;
  assign out_last  = out_valid & (pop_left_q == LEN_W'(1));
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign trunc_err = trunc_q;

  // Credit check: words already buffered or in flight, less the byte leaving
  // this cycle, must leave a free slot for the word this read will return.
  always_comb begin
    occupancy = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    issue     = (state_q == ST_RUN) && (rd_left_q != '0) &&
                (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    ram_rd    = issue;
    ram_addr  = issue ? rd_ptr_q : '0;
  end

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    rd_left_d  = rd_left_q;
    pop_left_d = pop_left_q;
    done_d     = 1'b0;
    trunc_d    = trunc_q | (inflight_q & has_trunc(ram_data));

    if (pop) pop_left_d = pop_left_q - LEN_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d    = ST_RUN;
            rd_ptr_d   = base_addr;
            rd_left_d  = length;
            pop_left_d = length;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (issue) begin
          rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
          rd_left_d = rd_left_q - LEN_W'(1);
          if (rd_left_q == LEN_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && (pop_left_q == LEN_W'(1))) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rd_ptr_q   <= '0;
      rd_left_q  <= '0;
      pop_left_q <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_left_q  <= rd_left_d;
      pop_left_q <= pop_left_d;
      inflight_q <= issue;
      done_q     <= done_d;
      trunc_q    <= trunc_d;
    end
  end

endmodule

// File: tb/tb_ram_to_tgm_reader.sv
// Randomised bench for ram_to_tgm_reader: a word-addressed RAM model plus an
// expected-byte queue per block, checked cycle by cycle on the falling edge.
module tb_ram_to_tgm_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  length;
  logic        ram_rd;
  logic [7:0]  ram_addr;
  logic [31:0] ram_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        trunc_err;

  logic [31:0] ram_mem [256];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  logic [7:0]  exp_bytes [$];
  logic [7:0]  blk_base;
  int          rd_issued, pops, done_cnt, done_cyc;
  int          first_rd_cyc, first_valid_cyc, first_pop_cyc, last_pop_cyc, start_cyc;
  bit          stall_prev;
  logic [7:0]  stall_data;
  bit          exp_trunc;
  int          rdy_mode;
  int          pat_idx;

  ram_to_tgm_reader #(.ADDR_W(8), .FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .ram_rd    (ram_rd),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .trunc_err (trunc_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_rd) ram_data <= ram_mem[ram_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_ram_rd"},    ram_rd,    0);
    check_eq({pfx, "_ram_addr"},  ram_addr,  0);
    check_eq({pfx, "_out_data"},  out_data,  0);
    check_eq({pfx, "_out_valid"}, out_valid, 0);
    check_eq({pfx, "_out_last"},  out_last,  0);
    check_eq({pfx, "_busy"},      busy,      0);
    check_eq({pfx, "_done"},      done,      0);
    check_eq({pfx, "_trunc_err"}, trunc_err, 0);
  endtask

  // Everything the DUT shows in one cycle, compared with the block's expected stream.
  task automatic monitor();
    logic [7:0] eb;
    logic [7:0] ea;
    if (stall_prev) begin
      check_eq("stall_valid", out_valid, 1);
      check_eq("stall_data", out_data, stall_data);
    end
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (out_valid && exp_bytes.size() == 0) begin
      check_eq("spurious_valid", out_valid, 0);
    end else if (out_valid && out_ready) begin
      eb = exp_bytes.pop_front();
      pops++;
      check_eq("byte", out_data, eb);
      check_eq("last", out_last, (exp_bytes.size() == 0) ? 1 : 0);
      if (exp_bytes.size() == 0) check_eq("busy_last_pop", busy, 1);
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
    end
    stall_prev = out_valid && !out_ready;
    stall_data = out_data;
    if (ram_rd) begin
      ea = blk_base + 8'(rd_issued);
      check_eq("rd_addr", ram_addr, ea);
      rd_issued++;
      check_eq("outstanding_le_2", ((rd_issued - pops) <= 2) ? 1 : 0, 1);
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check_eq("busy_at_done", busy, 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: begin
        out_ready = (pat_idx == 0 || pat_idx == 3);
        pat_idx   = (pat_idx + 1) % 4;
      end
    endcase
    @(negedge clk);
    if (!rst) monitor();
  endtask

  task automatic begin_block(input logic [7:0] base, input int len, input int mode);
    logic [31:0] w;
    rdy_mode = mode;
    pat_idx  = 0;
    exp_bytes.delete();
    for (int i = 0; i < len; i++) begin
      w = ram_mem[base + 8'(i)];
      exp_bytes.push_back(w[7:0]);
      if (w[31:8] != 24'h0) exp_trunc = 1'b1;
    end
    blk_base        = base;
    rd_issued       = 0;
    pops            = 0;
    done_cnt        = 0;
    done_cyc        = -1;
    first_rd_cyc    = -1;
    first_valid_cyc = -1;
    first_pop_cyc   = -1;
    last_pop_cyc    = -1;
    stall_prev      = 1'b0;
    start     = 1'b1;
    base_addr = base;
    length    = 9'(len);
    start_cyc = cyc + 1;
    step();
    start = 1'b0;
  endtask

  task automatic run_block(input logic [7:0] base, input int len, input int mode,
                           input bit chk_lat, input bit restart);
    begin_block(base, len, mode);
    if (restart) begin
      repeat (2) step();
      start     = 1'b1;
      base_addr = base + 8'h40;
      length    = 9'd3;
      step();
      start = 1'b0;
    end
    for (int i = 0; i < 4000 && done_cnt == 0; i++) step();
    if (done_cnt == 0) check_eq("done_timeout", 0, 1);
    repeat (3) step();
    check_eq("pop_count", pops, len);
    check_eq("read_count", rd_issued, len);
    check_eq("done_count", done_cnt, 1);
    check_eq("busy_after", busy, 0);
    check_eq("valid_after", out_valid, 0);
    check_eq("trunc_err", trunc_err, exp_trunc);
    if (len == 0) check_eq("done_cycle_len0", done_cyc, start_cyc);
    else          check_eq("done_cycle", done_cyc, last_pop_cyc + 1);
    if (chk_lat && len > 0) begin
      check_eq("lat_first_rd", first_rd_cyc, start_cyc);
      check_eq("lat_first_valid", first_valid_cyc, start_cyc + 2);
    end
    if (mode == 0 && len > 0) check_eq("throughput", last_pop_cyc - first_pop_cyc + 1, len);
    $display("block base=%02h len=%0d ready_mode=%0d restart=%0d -> bytes=%0d reads=%0d trunc_err=%0d",
             base, len, mode, restart, pops, rd_issued, trunc_err);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = 8'h00;
    length    = 9'd0;
    out_ready = 1'b0;
    rdy_mode  = 0;
    pat_idx   = 0;
    exp_trunc = 1'b0;
    for (int i = 0; i < 256; i++) ram_mem[i] = {24'h0, 8'($urandom)};
    for (int i = 0; i < 4; i++) ram_mem[i] = 32'(i + 1);

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;
    repeat (2) step();

    run_block(8'h00, 4, 0, 1'b1, 1'b0);
    run_block(8'h10, 6, 2, 1'b1, 1'b0);
    run_block(8'hFE, 4, 0, 1'b1, 1'b0);
    run_block(8'h00, 256, 0, 1'b0, 1'b0);
    run_block(8'h55, 0, 0, 1'b0, 1'b0);
    run_block(8'h10, 8, 1, 1'b0, 1'b1);

    ram_mem[2] = 32'h0000_0109;
    run_block(8'h00, 4, 0, 1'b0, 1'b0);
    run_block(8'h20, 5, 1, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      run_block(8'($urandom), int'($urandom_range(1, 40)), int'($urandom_range(0, 2)),
                1'b0, 1'b0);
    end

    // Abort a block part-way: everything must clear and never resume.
    begin_block(8'h30, 5, 0);
    for (int i = 0; i < 40 && pops < 2; i++) step();
    check_eq("mid_pops_before_rst", pops, 2);
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid");
    exp_trunc = 1'b0;
    exp_bytes.delete();
    rd_issued  = 0;
    pops       = 0;
    done_cnt   = 0;
    stall_prev = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    repeat (6) step();
    check_eq("post_rst_done", done_cnt, 0);
    check_eq("post_rst_reads", rd_issued, 0);
    check_eq("post_rst_busy", busy, 0);
    $display("reset mid-block: aborted after 2 of 5 bytes, busy=%0d", busy);

    run_block(8'h80, 10, 0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_to_tgm_reader.md
Name: ram_to_tgm_reader

Overview:
Read-side companion to the TGM output RAM. On a start command it reads a block of 32-bit words from the 256x32 RAM through the RAM's registered read port. It narrows each word to its 8-bit payload and streams the bytes to the next CNN stage over a valid/ready handshake. A 2-entry output FIFO absorbs the RAM read latency and downstream back-pressure.

Parameters:
- ADDR_W, 8, RAM address width; block length range is 0..2^ADDR_W.
- FIFO_DEPTH, 2, output buffer entries; the minimum value that sustains 1 byte/cycle.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  command strobe, sampled only in IDLE
- base_addr  in  8  first RAM address of the block
- length  in  9  number of words to read, 0..256
- ram_rd  out  1  RAM read enable
- ram_addr  out  8  RAM read address
- ram_data  in  32  RAM read data, valid the cycle after ram_rd
- out_data  out  8  streamed byte, ram_data[7:0]
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts the byte
- out_last  out  1  marks the final byte of the block
- busy  out  1  high from the start-accept edge until done
- done  out  1  one-cycle pulse when the block is complete
- trunc_err  out  1  sticky flag: some word read had ram_data[31:8] != 0

Behaviour:
- Reset (async): state=IDLE; FIFO empty; every output 0 (ram_rd, ram_addr, out_data, out_valid, out_last, busy, done, trunc_err).
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 and length!=0 -> RUN; rd_ptr=base_addr; rd_left=length; busy=1.
- IDLE: start=1 and length==0 -> done pulses the next cycle; busy stays 0; no RAM reads.
- Start is ignored while busy.
- RUN: ram_rd=1 and ram_addr=rd_ptr when rd_left!=0 and (fifo_count + inflight - pop) < FIFO_DEPTH.
  - inflight = ram_rd registered one cycle.
  - pop = out_valid & out_ready in the current cycle.
  - On each issued read: rd_ptr+1, wrapping 8'hFF -> 8'h00; rd_left-1.
- RUN -> DRAIN when the last read issues (rd_left becomes 0).
- Read capture: a cycle with inflight=1 pushes ram_data[7:0] into the FIFO.
  - The same cycle sets trunc_err if ram_data[31:8] != 0.
  - trunc_err stays set until rst.
  - The credit rule prevents the FIFO from overflowing.
- Output side: out_valid = FIFO not empty; out_data = FIFO head.
  - Head and valid hold stable while out_valid=1 and out_ready=0.
  - A simultaneous push and pop on a full FIFO is legal.
- out_last=1 only with the final byte of the block; it tracks pop count vs length.
- DRAIN -> IDLE on the pop of the last byte.
  - done pulses in the cycle after that pop; busy drops in the same cycle as the done pulse.
- Latency: start accepted at edge T -> ram_rd high in cycle T+1 -> data captured at edge T+2 -> out_valid high in cycle T+2+1.
- Throughput: with out_ready held 1, exactly 1 byte/cycle after the first.
- Wrap-around: base_addr=8'hFE with length=4 reads FE, FF, 00, 01.
- length=256 reads the whole RAM once.
- Back-pressure: out_ready=0 stalls reads after at most FIFO_DEPTH words are outstanding. No data is lost or duplicated.
- Mid-operation rst: immediate abort, reset values restored. No done pulse; the block is not resumed.

Decomposition:
- Package ram_tgm_pkg holds:
  - state encoding for IDLE/RUN/DRAIN;
  - ADDR_W and DATA_W=32;
  - PAYLOAD_W=8;
  - MAX_LEN=256.
- One sub-module, byte_fifo: synchronous FIFO, DEPTH and WIDTH parameters, async active-high rst, push/pop/count/head.
- The address generator, credit logic and FSM stay in the top module.

Test Plan:
- Basic read: RAM model holds 1,2,3,4 at addresses 0..3; start with base=0, len=4, out_ready=1. Expect bytes 01,02,03,04 on consecutive cycles; out_last on 04; one done pulse; trunc_err=0.
- Back-pressure: len=6; out_ready toggles 1,0,0,1 repeatedly. Expect exactly 6 bytes in order with none repeated; ram_rd never drives FIFO occupancy past 2; out_data stable while stalled.
- Wrap and full length: base=FE, len=4 -> ram_addr sequence FE, FF, 00, 01. Then base=00, len=256 -> 256 bytes; done after the 256th pop.
- Edge commands: len=0 -> done one cycle later, no ram_rd, busy=0. start pulsed again while busy -> ignored; the byte count is unchanged.
- Truncation: word at address 2 = 32'h0000_0109 -> out byte 09; trunc_err sets and stays set across the next block.
- Reset mid-block: assert rst after 2 of 5 bytes. Expect all outputs 0 immediately, no done pulse, FIFO empty. A new start then operates normally.
